// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle SLL/SRA shift sequencer.
package shift_sequencer_pkg;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  localparam int SHIFT_STAGES = 5;
  localparam logic [2:0] STAGE_TOP = 3'(SHIFT_STAGES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sequencer_stage.sv
// One barrel-shift stage: optionally shifts by 2^k, left (zero fill) or
// arithmetic right (sign fill from the MSB).
module shift_sequencer_stage
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       k,
  input  logic             en,
  input  logic             arith
);

  logic             sra;
  logic             fill;
  logic [WIDTH-1:0] sll_leg;
  logic [WIDTH-1:0] sra_leg;

  always_comb begin
    sra     = (arith == OP_SRA);
    fill    = sra & in[WIDTH-1];
    sll_leg = in;
    sra_leg = in;
    case (k)
      3'd0: begin
        sll_leg = {in[WIDTH-2:0], 1'b0};
        sra_leg = {fill, in[WIDTH-1:1]};
      end
      3'd1: begin
        sll_leg = {in[WIDTH-3:0], 2'b0};
        sra_leg = {{2{fill}}, in[WIDTH-1:2]};
      end
      3'd2: begin
        sll_leg = {in[WIDTH-5:0], 4'b0};
        sra_leg = {{4{fill}}, in[WIDTH-1:4]};
      end
      3'd3: begin
        sll_leg = {in[WIDTH-9:0], 8'b0};
        sra_leg = {{8{fill}}, in[WIDTH-1:8]};
      end
      3'd4: begin
        sll_leg = {in[WIDTH-17:0], 16'b0};
        sra_leg = {{16{fill}}, in[WIDTH-1:16]};
      end
      default: begin
        sll_leg = in;
        sra_leg = in;
      end
    endcase
    if (!en)      out = in;
    else if (sra) out = sra_leg;
    else          out = sll_leg;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: applies the 16/8/4/2/1 stages one per cycle,
// gated by the captured shift-amount bits, then holds the result for handshake.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter bit BYPASS_ZERO = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [4:0]       ctrl_shiftamt,
  input  logic             ctrl_shiftop,
  input  logic             ctrl_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [2:0]       stage_cnt_q, stage_cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       amt_q, amt_d;
  logic             op_q, op_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0] stage_out;

  shift_sequencer_stage #(.WIDTH(WIDTH)) u_stage (
    .out   (stage_out),
    .in    (acc_q),
    .k     (stage_cnt_q),
    .en    (amt_q[stage_cnt_q]),
    .arith (op_q)
  );

  always_comb begin
    state_d     = state_q;
    stage_cnt_d = stage_cnt_q;
    acc_d       = acc_q;
    amt_d       = amt_q;
    op_d        = op_q;
    case (state_q)
      ST_IDLE: begin
        // flush in IDLE suppresses the accept for that cycle
        if (in_valid && !ctrl_flush) begin
          acc_d       = data_operandA;
          amt_d       = ctrl_shiftamt;
          op_d        = ctrl_shiftop;
          stage_cnt_d = STAGE_TOP;
          if (BYPASS_ZERO && (ctrl_shiftamt == 5'd0)) state_d = ST_DONE;
          else                                         state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ctrl_flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = stage_out;
          if (stage_cnt_q == 3'd0) state_d = ST_DONE;
          else                     stage_cnt_d = stage_cnt_q - 3'd1;
        end
      end
      ST_DONE: begin
        if (ctrl_flush || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      stage_cnt_q <= STAGE_TOP;
      acc_q       <= '0;
      amt_q       <= '0;
      op_q        <= OP_SLL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_cnt_q <= stage_cnt_d;
      acc_q       <= acc_d;
      amt_q       <= amt_d;
      op_q        <= op_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign data_result = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and random checks of shift_sequencer with a result scoreboard.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_valid1;
  logic        out_ready, out_ready1;
  logic        ctrl_flush, ctrl_shiftop;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic        in_ready, out_valid, busy;
  logic        in_ready1, out_valid1, busy1;
  logic [31:0] data_result, data_result1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];

  always #5 clock = ~clock;

  shift_sequencer #(.WIDTH(32), .BYPASS_ZERO(1'b0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_operandA(data_operandA), .ctrl_shiftamt(ctrl_shiftamt),
    .ctrl_shiftop(ctrl_shiftop), .ctrl_flush(ctrl_flush), .out_valid(out_valid),
    .out_ready(out_ready), .data_result(data_result), .busy(busy)
  );

  shift_sequencer #(.WIDTH(32), .BYPASS_ZERO(1'b1)) dut_byp (
    .clock(clock), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .data_operandA(data_operandA), .ctrl_shiftamt(ctrl_shiftamt),
    .ctrl_shiftop(ctrl_shiftop), .ctrl_flush(ctrl_flush), .out_valid(out_valid1),
    .out_ready(out_ready1), .data_result(data_result1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s, input logic op);
    if (op == OP_SRA) return $signed(a) >>> s;
    return a << s;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic accept(input logic [31:0] a, input logic [4:0] s, input logic op);
    int n = 0;
    data_operandA = a;
    ctrl_shiftamt = s;
    ctrl_shiftop  = op;
    in_valid      = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check1("accept_ready", in_ready, 1'b1);
    @(posedge clock);
    sb.push_back(model(a, s, op));
    @(negedge clock);
    in_valid = 1'b0;
    check1("accept_busy", busy, 1'b1);
  endtask

  task automatic wait_result(input int exp_lat);
    int          lat = 0;
    logic [31:0] exp;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("sb_depth", 32'(sb.size()), 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 32'd0;
    check("result", data_result, exp);
  endtask

  task automatic finish(input int hold, input int exp_lat);
    logic [31:0] held;
    wait_result(exp_lat);
    held = data_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_stable", data_result, held);
      check1("hold_in_ready", in_ready, 1'b0);
      check1("hold_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check1("post_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic seen;
    logic [31:0] a;
    logic [4:0]  s;
    logic        op;

    reset = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0;
    out_ready1 = 1'b0; ctrl_flush = 1'b0; ctrl_shiftop = OP_SLL;
    data_operandA = '0; ctrl_shiftamt = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check("rst_result", data_result, 32'h0);

    accept(32'h0000_00FF, 5'd8, OP_SLL);  finish(0, 5);
    check("sll_ff_by8_abs", model(32'h0000_00FF, 5'd8, OP_SLL), 32'h0000_FF00);
    accept(32'h8000_0001, 5'd1, OP_SLL);  finish(0, 5);
    accept(32'h8000_0000, 5'd31, OP_SRA); finish(0, 5);
    accept(32'h7FFF_FFF0, 5'd4, OP_SRA);  finish(0, 5);
    accept(32'h8000_0000, 5'd31, OP_SRA); wait_result(5);
    check("sra31_neg", data_result, 32'hFFFF_FFFF);
    out_ready = 1'b1; @(negedge clock); out_ready = 1'b0;

    // reset pulled low two edges into a shift
    accept(32'h0000_1234, 5'd3, OP_SLL);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check1("midrst_out_valid", out_valid, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_in_ready", in_ready, 1'b1);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    accept(32'hA5A5_0F0F, 5'd12, OP_SRA); finish(0, 5);

    // result held while the consumer stalls; pending request waits for IDLE
    accept(32'hDEAD_BEEF, 5'd7, OP_SRA);
    data_operandA = 32'h0000_0003;
    ctrl_shiftamt = 5'd30;
    ctrl_shiftop  = OP_SLL;
    in_valid      = 1'b1;
    finish(10, 5);
    check1("exit_busy", busy, 1'b0);
    check1("exit_in_ready", in_ready, 1'b1);
    accept(32'h0000_0003, 5'd30, OP_SLL); finish(0, 5);

    // flush during SHIFT, sampled at the third edge after accept
    accept(32'h0000_0001, 5'd21, OP_SLL);
    @(negedge clock);
    @(negedge clock);
    ctrl_flush = 1'b1;
    @(negedge clock);
    ctrl_flush = 1'b0;
    check1("flush_busy", busy, 1'b0);
    check1("flush_in_ready", in_ready, 1'b1);
    void'(sb.pop_front());
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      seen = seen | out_valid;
    end
    check1("flush_no_valid", seen, 1'b0);

    in_valid = 1'b1; ctrl_flush = 1'b1;
    @(negedge clock);
    check1("flush_idle_busy", busy, 1'b0);
    check1("flush_idle_in_ready", in_ready, 1'b1);
    in_valid = 1'b0; ctrl_flush = 1'b0;

    // flush beats out_ready in DONE
    accept(32'h0000_00F0, 5'd2, OP_SLL); wait_result(5);
    ctrl_flush = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    ctrl_flush = 1'b0; out_ready = 1'b0;
    check1("flush_done_valid", out_valid, 1'b0);
    check1("flush_done_busy", busy, 1'b0);

    accept(32'hCAFE_F00D, 5'd0, OP_SLL); finish(0, 5);
    accept(32'h8765_4321, 5'd0, OP_SRA); finish(0, 5);

    // zero-bypass instance: completes within one cycle of the accept edge
    data_operandA = 32'h1357_9BDF; ctrl_shiftamt = 5'd0; ctrl_shiftop = OP_SRA;
    in_valid1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check1("byp_zero_fast", (lat <= 1), 1'b1);
    check("byp_zero_result", data_result1, 32'h1357_9BDF);
    out_ready1 = 1'b1; @(negedge clock); out_ready1 = 1'b0;
    check1("byp_post_valid", out_valid1, 1'b0);

    data_operandA = 32'h8000_0000; ctrl_shiftamt = 5'd3; ctrl_shiftop = OP_SRA;
    in_valid1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("byp_nonzero_lat", 32'(lat), 32'd5);
    check("byp_nonzero_result", data_result1, 32'hF000_0000);
    out_ready1 = 1'b1; @(negedge clock); out_ready1 = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      a  = $urandom;
      s  = 5'($urandom_range(0, 31));
      op = 1'($urandom_range(0, 1));
      accept(a, s, op);
      finish($urandom_range(0, 2), 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
